// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and
// restoring divide on magnitudes, fixed XLEN+1 cycle latency for every op.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_bop;
  logic [2:0]        r_op;
  logic              r_neg;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic              w_neg;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_trial;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod_neg;
  logic [XLEN-1:0]   w_lo_fix;
  logic [XLEN-1:0]   w_hi_fix;
  logic [XLEN-1:0]   w_res;

  assign w_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign w_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign w_a_neg    = w_a_signed & a[XLEN-1];
  assign w_b_neg    = w_b_signed & b[XLEN-1];
  assign w_a_abs    = w_a_neg ? -a : a;
  assign w_b_abs    = w_b_neg ? -b : b;

  // A zero divisor must leave the all-ones quotient unnegated, so DIV by zero
  // returns all ones whatever the dividend sign.
  always_comb begin
    w_neg = 1'b0;
    case (op[2:1])
      2'b10:   w_neg = (w_a_neg ^ w_b_neg) & (|b);
      2'b11:   w_neg = w_a_neg;
      default: w_neg = w_a_neg ^ w_b_neg;
    endcase
  end

  // Multiply: upper half accumulates, lower half holds the shifting multiplier.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_bop};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]}
                               : {1'b0, r_acc[2*XLEN-1:1]};

  // Divide: upper half is the partial remainder, lower half dividend/quotient.
  assign w_trial    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_bop};
  assign w_div_next = w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                    : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prod_neg = -r_acc;
  assign w_lo_fix   = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_hi_fix   = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_res = w_lo_fix;
    case (r_op)
      3'b001, 3'b010, 3'b011:
        w_res = r_neg ? w_prod_neg[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
      3'b110, 3'b111:
        w_res = w_hi_fix;
      default:
        w_res = w_lo_fix;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_bop    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_neg   <= w_neg;
            r_cnt   <= '0;
            r_acc   <= op[2] ? {{XLEN{1'b0}}, w_a_abs} : {{XLEN{1'b0}}, w_b_abs};
            r_bop   <= op[2] ? w_b_abs : w_a_abs;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(XLEN - 1)) r_state <= S_FIN;
        end
        S_FIN: begin
          r_result <= w_res;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases, back-to-back,
// reset abort and randomized ops against a plain-arithmetic reference model.
module tb_mul_div_unit;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(XLEN)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sx;
    longint          sy;
    longint          p;
    logic [63:0]     pu;
    logic [63:0]     ux;
    logic [63:0]     uy;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (f)
      3'd0: begin pu = ux * uy; return pu[31:0]; end
      3'd1: begin p = sx * sy; pu = p; return pu[63:32]; end
      3'd2: begin p = sx * longint'(uy); pu = p; return pu[63:32]; end
      3'd3: begin pu = ux * uy; return pu[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = sx / sy; pu = p; return pu[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        p = sx % sy; pu = p; return pu[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // One full operation: checks result, latency, busy length and done width,
  // while scrambling inputs and pulsing start mid-flight.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] exp;
    int          lat;
    int          busy_cnt;
    bit          seen;
    exp = model(f, x, y);
    @(negedge clk);
    start = 1'b1; op = f; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; seen = 1'b0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= LAT + 8 && !seen; i++) begin
      op = 3'($urandom); a = $urandom; b = $urandom;
      start = (i == 5 || i == 17);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin seen = 1'b1; lat = i; end
    end
    check({tag, ".result"}, result, exp);
    check({tag, ".latency"}, lat, LAT);
    check({tag, ".busy_cycles"}, busy_cnt, LAT);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, done, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1;
    int d2;
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    #1;
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.result", result, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD);
    check("mul_7_m3.const", result, 32'hFFFF_FFEB);
    do_op("mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000);
    check("mulh_min.const", result, 32'h4000_0000);
    do_op("mulhu_ones",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_ones.const", result, 32'hFFFF_FFFE);
    do_op("mulhsu_ones",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhsu_ones.const", result, 32'hFFFF_FFFF);
    do_op("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2.const", result, 32'hFFFF_FFFD);
    do_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2);
    check("rem_m7_2.const", result, 32'hFFFF_FFFF);
    do_op("divu_100_7",   3'd5, 32'd100, 32'd7);
    check("divu_100_7.const", result, 32'd14);
    do_op("remu_100_7",   3'd7, 32'd100, 32'd7);
    check("remu_100_7.const", result, 32'd2);
    do_op("div_5_0",      3'd4, 32'd5, 32'd0);
    check("div_5_0.const", result, 32'hFFFF_FFFF);
    do_op("div_m5_0",     3'd4, 32'hFFFF_FFFB, 32'd0);
    do_op("remu_5_0",     3'd7, 32'd5, 32'd0);
    check("remu_5_0.const", result, 32'd5);
    do_op("rem_m5_0",     3'd6, 32'hFFFF_FFFB, 32'd0);
    do_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf.const", result, 32'h8000_0000);
    do_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    check("rem_ovf.const", result, 32'h0);

    // Back-to-back: start stays high; second op is accepted in the done cycle.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    op = 3'd5; a = 32'd12; b = 32'd4;
    d1 = 0; d2 = 0;
    for (int t = 1; t <= 3 * LAT; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (d1 == 0) begin
          d1 = t;
          check("b2b.first_result", result, 32'd12);
        end else begin
          d2 = t;
          check("b2b.second_result", result, 32'd3);
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b.first_latency", d1, LAT);
    check("b2b.gap", d2 - d1, LAT + 1);
    @(posedge clk);
    @(negedge clk);
    check("b2b.idle_after", busy, 1'b0);

    // Reset mid-way through a DIVU aborts it immediately and silently.
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid.busy", busy, 1'b0);
    check("rst_mid.done", done, 1'b0);
    check("rst_mid.result", result, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("rst_mid.no_done", done, 1'b0);
    end
    rst = 1'b0;
    d1 = 0;
    for (int t = 0; t < LAT + 4; t++) begin
      @(negedge clk);
      if (done) d1 = 1;
    end
    check("rst_mid.stale_done", d1, 0);
    do_op("rst_mul_2_3", 3'd0, 32'd2, 32'd3);
    check("rst_mul_2_3.const", result, 32'd6);

    for (int k = 0; k < 150; k++) begin
      do_op($sformatf("rand%0d", k), 3'($urandom), pick(), pick());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values even, 4..64.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  operation (RISC-V M funct3): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a  input  XLEN  operand rs1 (dividend / multiplicand).
REQ-007 b  input  XLEN  operand rs2 (divisor / multiplier).
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 result  output  XLEN  registered result; held until next done or reset.

Function
REQ-011 FSM states IDLE, CALC, FIN; IDLE->CALC on start=1; CALC->FIN after XLEN iteration edges; FIN->IDLE on next edge.
REQ-012 Start edge (E0): latch op, absolute-value operands, result signs; clear iteration counter; busy=1.
REQ-013 Edges E1..E(XLEN): one iteration each; multiply = shift-add, 2*XLEN-bit accumulator; divide = restoring, one quotient bit per edge.
REQ-014 Edge E(XLEN+1): apply sign correction, write result, done=1, busy=0; fixed latency XLEN+1 edges after E0 for every op and every operand value.
REQ-015 done high exactly one cycle; deasserted on following edge regardless of start.
REQ-016 start=1 in the cycle done=1 is accepted (back-to-back, no idle gap); start while busy=1 ignored, in-flight operands/op unaffected by input changes.
REQ-017 Signedness: MULH both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned; DIV/REM signed.
REQ-018 MUL returns low XLEN bits of product; MULH/MULHSU/MULHU return high XLEN bits.
REQ-019 DIV rounds toward zero; REM sign equals dividend sign; a = q*b + r holds.
REQ-020 Divide by zero: DIV/DIVU result all ones; REM/REMU result = a.
REQ-021 Signed overflow (a = most-negative, b = all ones): DIV result = a; REM result = 0.
REQ-022 Special cases (REQ-020/021) still obey REQ-014 latency; no early done.
REQ-023 No exceptions, no flags; inputs with X outside start cycle have no effect.

Reset
REQ-024 rst=1: state IDLE, busy=0, done=0, result=0, counter=0, immediately (asynchronous).
REQ-025 rst during CALC/FIN aborts operation; no done pulse for it; first start after rst release begins a fresh operation.

Verification
REQ-026 MUL a=7, b=0xFFFFFFFD -> done exactly 33 edges after start edge, result 0xFFFFFFEB; busy high 33 cycles.
REQ-027 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-028 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-029 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; all at standard latency.
REQ-030 Back-to-back: start held high through two ops (MUL 3*4, then DIVU 12/4) -> done pulses 12 then 3, consecutive operations separated by zero idle cycles; start pulses during busy ignored.
REQ-031 Reset mid-op: rst asserted at iteration 10 of DIVU -> busy/done/result 0 same cycle, no done; new MUL 2*3 after release -> 6 at standard latency.
